// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the 2x2 int32 matmul pipe and its result checker.
//   Element geometry, tuple field offsets, checker FSM state type and a per-element
//   mismatch helper. Used by both the stimulus side and the checker.
package matmul_pkg;

    localparam int unsigned ELEM_W   = 32;
    localparam int unsigned DIM      = 2;
    localparam int unsigned NUM_ELEM = DIM * DIM;
    localparam int unsigned MAT_W    = 128;
    localparam int unsigned TUPLE_W  = 384;

    // Field offsets inside the pipe output tuple {a, b, a*b}
    localparam int unsigned PROD_LSB = 0;
    localparam int unsigned B_LSB    = 128;
    localparam int unsigned A_LSB    = 256;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } chk_state_t;

    // Bit 2i+j set when element [i][j] of got and exp differ in any bit.
    function automatic logic [NUM_ELEM-1:0] elem_mismatch(input logic [MAT_W-1:0] got,
                                                          input logic [MAT_W-1:0] exp);
        logic [NUM_ELEM-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            m[k] = |(got[k*ELEM_W +: ELEM_W] ^ exp[k*ELEM_W +: ELEM_W]);
        end
        return m;
    endfunction

endpackage

// File: rtl/matmul_delay_line.sv
// matmul_delay_line: WIDTH x DEPTH shift register with asynchronous and synchronous clear.
//   clk    in  clock, rising edge
//   rst    in  asynchronous clear, active-high
//   flush  in  synchronous clear of every stage
//   din    in  WIDTH  data entering stage 0
//   dout   out WIDTH  data leaving the last stage, DEPTH edges after entry
module matmul_delay_line #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_result_checker.sv
// matmul_result_checker: checks the product field of the 2x2 int32 matmul pipe output.
//   The pipe carries no valid, so in_valid and exp_result travel through a delay line of
//   matching depth and emerge alongside the corresponding dut_out tuple.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    starts a run from IDLE or DONE (ignored in RUN)
//   num_vectors [CNT_W]      vectors to check, sampled on an accepted start
//   in_valid                 a/b/exp presented to the pipe input this cycle
//   exp_result [128]         expected product, element [i][j] at (2i+j)*32
//   dut_out [384]            pipe output {a, b, a*b}
//   busy / done              state is RUN / DONE
//   error                    sticky mismatch flag for the current run
//   pass_count, fail_count   saturating result counters
//   fail_mask [4]            per-element mismatch of the latest failing vector
//   first_fail_index         0-based ordinal of the first failing vector
// Optional build macro MATMUL_CHK_CAPTURE_EN adds fail_a/fail_b/fail_got/fail_exp, the
// operands, product and expectation of the first failing vector of the run.
module matmul_result_checker
    import matmul_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vectors,
    input  logic                in_valid,
    input  logic [MAT_W-1:0]    exp_result,
    input  logic [TUPLE_W-1:0]  dut_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [NUM_ELEM-1:0] fail_mask,
    output logic [CNT_W-1:0]    first_fail_index
`ifdef MATMUL_CHK_CAPTURE_EN
    ,
    output logic [MAT_W-1:0]    fail_a,
    output logic [MAT_W-1:0]    fail_b,
    output logic [MAT_W-1:0]    fail_got,
    output logic [MAT_W-1:0]    fail_exp
`endif
);

    chk_state_t          state_q;
    logic [CNT_W-1:0]    num_q;
    logic [CNT_W-1:0]    check_cnt_q;
    logic [CNT_W-1:0]    check_cnt_inc;

    logic                start_ok;
    logic [MAT_W:0]      dl_in;
    logic [MAT_W:0]      dl_out;
    logic                dly_valid;
    logic [MAT_W-1:0]    dly_exp;
    logic [MAT_W-1:0]    got;
    logic [NUM_ELEM-1:0] mask;
    logic                do_check;

    assign start_ok = start && (state_q != RUN);

    // Outside RUN the valid entering the line is forced low.
    assign dl_in = {in_valid && (state_q == RUN), exp_result};

    matmul_delay_line #(
        .WIDTH (MAT_W + 1),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign dly_valid     = dl_out[MAT_W];
    assign dly_exp       = dl_out[MAT_W-1:0];
    assign got           = dut_out[PROD_LSB +: MAT_W];
    assign mask          = elem_mismatch(got, dly_exp);
    // Late arrivals after DONE are dropped here.
    assign do_check      = dly_valid && (state_q == RUN);
    assign check_cnt_inc = check_cnt_q + CNT_W'(1);

`ifndef MATMUL_CHK_CAPTURE_EN
    // Echo fields are never compared in this build.
    logic unused_echo;
    assign unused_echo = ^dut_out[TUPLE_W-1:MAT_W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            num_q            <= '0;
            check_cnt_q      <= '0;
            error            <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            fail_mask        <= '0;
            first_fail_index <= '0;
`ifdef MATMUL_CHK_CAPTURE_EN
            fail_a           <= '0;
            fail_b           <= '0;
            fail_got         <= '0;
            fail_exp         <= '0;
`endif
        end else if (start_ok) begin
            state_q          <= (num_vectors == '0) ? DONE : RUN;
            num_q            <= num_vectors;
            check_cnt_q      <= '0;
            error            <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            fail_mask        <= '0;
            first_fail_index <= '0;
`ifdef MATMUL_CHK_CAPTURE_EN
            fail_a           <= '0;
            fail_b           <= '0;
            fail_got         <= '0;
            fail_exp         <= '0;
`endif
        end else if (do_check) begin
            check_cnt_q <= check_cnt_inc;
            if (mask == '0) begin
                if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
            end else begin
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                error     <= 1'b1;
                fail_mask <= mask;
                // error still low means this is the first failure of the run
                if (!error) begin
                    first_fail_index <= check_cnt_q;
`ifdef MATMUL_CHK_CAPTURE_EN
                    fail_a           <= dut_out[A_LSB +: MAT_W];
                    fail_b           <= dut_out[B_LSB +: MAT_W];
                    fail_got         <= got;
                    fail_exp         <= dly_exp;
`endif
                end
            end
            if (check_cnt_inc == num_q) state_q <= DONE;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
